program_counter: RTL and testbench

- Program-counter register of the single-cycle MIPS datapath.
- Each clock it latches the next-PC address from the NPC block and presents the instruction-memory word index to IM.
- IM is 1024 words, so the index is the byte address bits [11:2].
- Text segment base is 0x0000_3000; its word index is 0.

---
 rtl/program_counter_pkg.sv | 15 +
 rtl/program_counter_if.sv | 28 ++
 rtl/program_counter.sv | 40 ++++
 tb/tb_program_counter.sv | 143 ++++++++++++++
 4 files changed

// File: rtl/program_counter_pkg.sv
// Shared definitions for the program-counter slice of the single-cycle MIPS datapath.
// Holds the text-segment base, the instruction-memory index width and the address type.
// Imported by the interface and the PC register.
package program_counter_pkg;

  // Byte address of the first instruction in the text segment (word index 0).
  localparam logic [31:0] TEXT_BASE = 32'h0000_3000;

  // IM holds 2^IM_IDX_W words, so the word index is byte-address bits [IM_IDX_W+1:2].
  localparam int IM_IDX_W = 10;

  // Full 32-bit byte address as carried between PC, NPC and IM.
  typedef logic [31:0] word_addr_t;

endpackage : program_counter_pkg

// File: rtl/program_counter_if.sv
// Bus between the NPC block and the PC register.
// NPC drives the next byte address. PC returns the IM word index and its full current address.
// The full address is what NPC uses to form PC+4 and branch/jump targets.
interface program_counter_if
  import program_counter_pkg::*;
#(
  parameter int IDX_W = IM_IDX_W
) ();

  word_addr_t       npc_out_addr;  // next-PC byte address from NPC
  logic [IDX_W-1:0] pc_out;        // IM word index of the current PC
  word_addr_t       pc_addr;       // current PC byte address, fed back to NPC

  // NPC side: supplies the next address and observes the current PC.
  modport master (
    output npc_out_addr,
    input  pc_out,
    input  pc_addr
  );

  // PC register side.
  modport slave (
    input  npc_out_addr,
    output pc_out,
    output pc_addr
  );

endinterface : program_counter_if

// File: rtl/program_counter.sv
// Program-counter register: latches the NPC byte address every rising edge and presents the IM word index.
// Latency: one rising edge from npc_out_addr to pc_out; pc_out is combinational from the register.
// Backpressure: none. There is no stall or enable, so the PC updates on every clock.
module program_counter
  import program_counter_pkg::*;
#(
  parameter word_addr_t RESET_ADDR = TEXT_BASE,
  parameter int         IDX_W      = IM_IDX_W
) (
  input  logic               clk,
  input  logic               rst_pc,
  program_counter_if.slave   bus
);

  // Start from the text base so the index reads 0 before any edge or reset has happened.
  word_addr_t pc_q = RESET_ADDR;
  word_addr_t pc_d;

  // Next address is always the NPC value. Reset overrides it in the register process.
  always_comb begin
    pc_d = bus.npc_out_addr;
  end

  // Synchronous reset has priority. An unknown rst_pc is not 1, so it takes the load path.
  always_ff @(posedge clk) begin
    if (rst_pc == 1'b1) begin
      pc_q <= RESET_ADDR;
    end else begin
      pc_q <= pc_d;
    end
  end

  // Bits [1:0] select a byte within the word and are dropped.
  // High bits above the IM window are dropped too, so the index wraps modulo the IM depth.
  always_comb begin
    bus.pc_out  = pc_q[IDX_W+1:2];
    bus.pc_addr = pc_q;
  end

endmodule : program_counter

// File: tb/tb_program_counter.sv
// Self-checking bench for program_counter.
// A reference model tracks the PC byte address and is checked on every falling edge.
// Directed scenarios are checked against hand-computed indices, then the model runs under random stimulus.
module tb_program_counter;
  import program_counter_pkg::*;

  localparam logic [31:0] RST_A = 32'h0000_3000;

  logic clk = 1'b0;
  logic rst_pc;  // left undriven (X) at start on purpose
  int   total = 0;
  int   bad   = 0;
  bit   model_on = 1'b0;

  logic [31:0] exp_addr = RST_A;  // model: current PC byte address

  program_counter_if #(.IDX_W(10)) pc_bus ();

  program_counter #(.RESET_ADDR(RST_A), .IDX_W(10)) dut (
    .clk    (clk),
    .rst_pc (rst_pc),
    .bus    (pc_bus.slave)
  );

  always #5 clk = ~clk;

  // Expected IM index: the byte address divided by 4, wrapped to 1024 words.
  function automatic logic [9:0] idx_of(input logic [31:0] a);
    return 10'((a / 4) % 1024);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", name, act, req, $time);
    end
  endtask

  // Reference model: on each rising edge the PC becomes RESET_ADDR if reset is exactly 1, otherwise the NPC value.
  always @(posedge clk) begin
    if (rst_pc === 1'b1) exp_addr = RST_A;
    else                 exp_addr = pc_bus.npc_out_addr;
  end

  // Compare outputs against the model mid-cycle, away from the active edge.
  always @(negedge clk) begin
    if (model_on) begin
      check("model_idx", {22'd0, pc_bus.pc_out}, {22'd0, idx_of(exp_addr)});
      check("model_addr", pc_bus.pc_addr, exp_addr);
    end
  end

  // Wait for the next rising edge, then settle 1 time unit past it.
  task automatic edge_wait();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [31:0] a;
    pc_bus.npc_out_addr = 32'h0000_3004;
    #1;
    check("powerup_idx", {22'd0, pc_bus.pc_out}, 32'd0);
    model_on = 1'b1;

    // No reset ever asserted: PC follows NPC.
    edge_wait();
    check("first_load", {22'd0, pc_bus.pc_out}, 32'd1);
    pc_bus.npc_out_addr = 32'h0000_3008;
    edge_wait();
    check("second_load", {22'd0, pc_bus.pc_out}, 32'd2);

    // Sequential increment: indices 3..10, each one edge after the input.
    for (int i = 0; i < 8; i++) begin
      pc_bus.npc_out_addr = 32'h0000_300C + 32'(4 * i);
      #1;
      check("incr_hold", {22'd0, pc_bus.pc_out}, 32'(2 + i));
      edge_wait();
      check("incr_step", {22'd0, pc_bus.pc_out}, 32'(3 + i));
    end

    // Move to index 5, then assert reset mid-cycle together with a new NPC value.
    pc_bus.npc_out_addr = 32'h0000_3014;
    edge_wait();
    check("at_five", {22'd0, pc_bus.pc_out}, 32'd5);
    #1;
    rst_pc = 1'b1;
    pc_bus.npc_out_addr = 32'h0000_3020;
    #1;
    check("rst_midcycle", {22'd0, pc_bus.pc_out}, 32'd5);
    edge_wait();
    check("rst_priority", {22'd0, pc_bus.pc_out}, 32'd0);
    check("rst_addr", pc_bus.pc_addr, 32'h0000_3000);
    edge_wait();
    check("rst_held", {22'd0, pc_bus.pc_out}, 32'd0);
    rst_pc = 1'b0;
    pc_bus.npc_out_addr = 32'h0000_300C;
    edge_wait();
    check("rst_release", {22'd0, pc_bus.pc_out}, 32'd3);

    // Boundary, wrap and misalignment.
    pc_bus.npc_out_addr = 32'h0000_3FFC;
    edge_wait();
    check("top_word", {22'd0, pc_bus.pc_out}, 32'h3FF);
    pc_bus.npc_out_addr = 32'h0000_4000;
    edge_wait();
    check("wrap", {22'd0, pc_bus.pc_out}, 32'h000);
    check("wrap_addr", pc_bus.pc_addr, 32'h0000_4000);
    pc_bus.npc_out_addr = 32'h0000_3006;
    edge_wait();
    check("misaligned", {22'd0, pc_bus.pc_out}, 32'd1);

    // Glitch: only the value present at the rising edge is captured.
    pc_bus.npc_out_addr = 32'h0000_3010;
    #2;
    pc_bus.npc_out_addr = 32'h0000_3040;
    #2;
    pc_bus.npc_out_addr = 32'h0000_3018;
    edge_wait();
    check("glitch", {22'd0, pc_bus.pc_out}, 32'd6);

    // Random stimulus. Reset is sometimes 1, sometimes X, and the address is any 32-bit value.
    for (int i = 0; i < 300; i++) begin
      a = $urandom;
      if ($urandom_range(0, 1) == 0) a = 32'h0000_3000 + (a & 32'h0000_1FFF);
      pc_bus.npc_out_addr = a;
      case ($urandom_range(0, 9))
        0, 1:    rst_pc = 1'b1;
        2:       rst_pc = 1'bx;
        default: rst_pc = 1'b0;
      endcase
      edge_wait();
      #($urandom_range(0, 3));
    end

    edge_wait();
    model_on = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_program_counter
